// File: rtl/gy26_responder.sv
// GY-26 compass responder: 8N1 UART command receiver and ASCII angle frame transmitter.
// Optional calibration-mode flag is built only when GY26_CAL_EN is defined.
module gy26_responder #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [7:0]  CMD_ANGLE = 8'h31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    input  logic [11:0] angle,
    output logic        busy,
    output logic        frame_done
`ifdef GY26_CAL_EN
    ,
    output logic        cal_active
`endif
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [11:0] ANGLE_MAX = 12'd3599;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_CONVERT, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

    logic [2:0]       rx_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_valid;
    logic [7:0]       rx_byte;

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bits;
    logic [2:0]       byte_idx;
    logic [7:0]       tx_shift;
    logic [11:0]      rem;
    logic [1:0]       phase;
    logic [3:0]       d_hun;
    logic [3:0]       d_ten;
    logic [3:0]       d_one;

    logic             rx_bit_c;
    logic             rx_prev_c;
    logic             cmd_accept_c;
    logic [11:0]      angle_clamped_c;
    logic [11:0]      weight_c;

    assign rx_bit_c        = rx_sync[1];
    assign rx_prev_c       = rx_sync[2];
    assign cmd_accept_c    = rx_valid && (rx_byte == CMD_ANGLE) && !busy;
    assign angle_clamped_c = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;

    // Decimal weight subtracted during the current conversion phase.
    always_comb begin
        weight_c = 12'd10;
        case (phase)
            2'd0:    weight_c = 12'd1000;
            2'd1:    weight_c = 12'd100;
            default: weight_c = 12'd10;
        endcase
    end

    // Reply byte for a given frame position, built from the converted digits.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx);
        logic [7:0] b2, b3, b4, b6;
        b2 = 8'h30 + 8'(d_hun);
        b3 = 8'h30 + 8'(d_ten);
        b4 = 8'h30 + 8'(d_one);
        b6 = 8'h30 + 8'(rem[3:0]);
        case (idx)
            3'd0:    frame_byte = 8'h0D;
            3'd1:    frame_byte = 8'h0A;
            3'd2:    frame_byte = b2;
            3'd3:    frame_byte = b3;
            3'd4:    frame_byte = b4;
            3'd5:    frame_byte = 8'h2E;
            3'd6:    frame_byte = b6;
            default: frame_byte = 8'h0D + 8'h0A + b2 + b3 + b4 + 8'h2E + b6;
        endcase
    endfunction

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) rx_sync <= 3'b111;
        else     rx_sync <= {rx_sync[1:0], rxd};
    end

    // 8N1 receiver: mid-bit sampling, framing errors silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_bit_c && rx_prev_c) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt  <= '0;
                        rx_bits <= '0;
                        rx_state <= rx_bit_c ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_bit_c, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                        else                 rx_bits  <= rx_bits + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_bit_c) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Reply sequencer: digit conversion by repeated subtraction, then 8 back-to-back 8N1 bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_cnt     <= '0;
            tx_bits    <= '0;
            byte_idx   <= '0;
            tx_shift   <= '0;
            rem        <= '0;
            phase      <= '0;
            d_hun      <= '0;
            d_ten      <= '0;
            d_one      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (cmd_accept_c) begin
                        busy     <= 1'b1;
                        rem      <= angle_clamped_c;
                        phase    <= '0;
                        d_hun    <= '0;
                        d_ten    <= '0;
                        d_one    <= '0;
                        tx_state <= TX_CONVERT;
                    end
                end
                TX_CONVERT: begin
                    if (rem >= weight_c) begin
                        rem <= rem - weight_c;
                        case (phase)
                            2'd0:    d_hun <= d_hun + 1'b1;
                            2'd1:    d_ten <= d_ten + 1'b1;
                            default: d_one <= d_one + 1'b1;
                        endcase
                    end else if (phase == 2'd2) begin
                        tx_shift <= 8'h0D;
                        txd      <= 1'b0;
                        tx_cnt   <= '0;
                        byte_idx <= '0;
                        tx_state <= TX_START;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bits  <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bits == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bits  <= tx_bits + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (byte_idx != 3'd7) begin
                            byte_idx <= byte_idx + 1'b1;
                            tx_shift <= frame_byte(3'(byte_idx + 3'd1));
                            txd      <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            frame_done <= 1'b1;
                            tx_state   <= TX_DONE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DONE: begin
                    busy     <= 1'b0;
                    tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef GY26_CAL_EN
    // Calibration flag: C0 enters (only when idle), C1 leaves; neither triggers a reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_active <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == 8'hC0 && !busy) cal_active <= 1'b1;
            else if (rx_byte == 8'hC1)     cal_active <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/gy26_responder.md
Name: gy26_responder

Overview:
- Emulates the GY-26 electronic compass on the sensor side of the UART link: receives host command bytes and answers an angle request with the 8-byte ASCII angle frame.
- Used as a stand-in sensor for board bring-up and as the far-end model in host-side UART regression.
- Contains its own 8N1 receiver, 8N1 transmitter, binary-to-ASCII converter and checksum generator.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. Bit period is CLKS_PER_BIT = CLK_FREQ/BAUD clocks, using integer division.
- CMD_ANGLE, 8'h31, command byte that triggers an angle reply.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  serial command line from the host; idle high; asynchronous to clk.
- txd  output  1  serial reply line to the host; idle high.
- angle  input  12  heading in tenths of a degree, 0..3599.
- busy  output  1  high from command acceptance until the reply stop bit ends.
- frame_done  output  1  one-clock pulse when the last stop bit of a reply completes.
- cal_active  output  1  calibration mode flag; present only when GY26_CAL_EN is defined.

Behaviour:
- Reset:
  - txd=1, busy=0, frame_done=0, cal_active=0.
  - All state machines return to IDLE.
  - A reply in flight is abandoned; txd is high on the cycle after rst is sampled.
- RX path:
  - rxd passes through a 2-FF synchronizer.
  - A falling edge in RX_IDLE starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, return to RX_IDLE.
  - Data bits are sampled every CLKS_PER_BIT after that point, LSB first.
  - The stop bit must sample 1. Otherwise the byte is discarded as a framing error and no action is taken.
- Command decode, on a valid byte:
  - CMD_ANGLE while busy=0: latch angle, set busy on the next cycle, start the reply.
  - CMD_ANGLE while busy=1: ignored. No queueing.
  - Any other byte: ignored, except as described under Optional Feature.
- Angle conversion:
  - A latched value above 3599 is clamped to 3599.
  - Split into hundreds, tens, ones and tenths digits, each 0..9. Conversion may be sequential.
  - The reply start bit must begin within 40 clocks of accepting the command.
- Reply frame, 8 bytes, each sent 8N1 LSB first, back-to-back with no idle gap between a stop bit and the next start bit:
  - B0=8'h0D, B1=8'h0A.
  - B2=8'h30+hundreds, B3=8'h30+tens, B4=8'h30+ones.
  - B5=8'h2E ('.').
  - B6=8'h30+tenths.
  - B7=checksum, the low 8 bits of B0+B1+...+B6.
- TX state machine:
  - States: TX_IDLE -> CONVERT -> START -> DATA(8 bits) -> STOP.
  - From STOP: go to START if byte_idx<7; otherwise go to DONE.
  - DONE lasts one clock, pulses frame_done, clears busy, then returns to TX_IDLE.
  - Each bit, start and stop included, lasts exactly CLKS_PER_BIT clocks.
- Concurrency:
  - RX keeps running during TX.
  - A command whose stop bit validates in the same cycle as DONE is ignored, because busy is still 1.
- Input stability: the angle input may change freely after latch; the frame already being sent is unaffected.

Optional Feature:
- Macro: GY26_CAL_EN.
- Defined:
  - Byte 8'hC0 with busy=0 sets cal_active=1.
  - Byte 8'hC1 clears cal_active.
  - Neither byte produces a reply.
  - While cal_active=1, CMD_ANGLE is still answered normally.
- Undefined:
  - The cal_active port and its logic are absent.
  - 8'hC0 and 8'hC1 are ignored like any other unknown byte.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so 10 clocks/bit):
- angle=1234, send 8'h31 -> txd carries 0D 0A 31 32 33 2E 34 0F; busy high throughout; single frame_done pulse; total reply length 800 clocks.
- angle=0, send 8'h31 -> reply 0D 0A 30 30 30 2E 30 05.
- angle=4000 (clamp), send 8'h31 -> reply 0D 0A 33 35 39 2E 39 1F.
- Second 8'h31 sent during a reply -> exactly one frame is produced; a 8'h31 sent after frame_done produces a second frame.
- 8'h31 sent with stop bit forced to 0, and a 5-clock glitch low on rxd -> no reply, busy stays 0.
- Assert rst in the middle of byte B3 -> txd=1 and busy=0 on the next cycle; a following 8'h31 yields a complete, correct frame.
- With GY26_CAL_EN defined: send 8'hC0 -> cal_active=1 and no txd activity; send 8'hC1 -> cal_active=0.
